ram_port_arbiter: RTL and testbench

- Two-master arbiter in front of the SoC's single-port data RAM (4096 x 64-bit, synchronous read).
- Master 0 is the CPU load/store port. Master 1 is the debug/program-loader port, which lets a bench or UART loader preload and inspect RAM while the core runs.
- Arbitration is round-robin with an optional bounded lock for back-to-back bursts.
- Read responses are routed back to the requester one cycle after grant.

---
 rtl/ram_arb_pkg.sv | 21 ++
 rtl/ram_port_arbiter_if.sv | 52 +++++
 rtl/ram_port_arbiter_rr_lock_sel.sv | 94 +++++++++
 rtl/ram_port_arbiter.sv | 121 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for the data-RAM port arbiter.
// Owner encoding, master ids and default bus widths.
package ram_arb_pkg;

  localparam int ARB_ADDR_W = 12;
  localparam int ARB_DATA_W = 64;

  localparam logic MID_0 = 1'b0;
  localparam logic MID_1 = 1'b1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_M0   = 2'b01,
    OWN_M1   = 2'b10
  } owner_t;

  function automatic owner_t own_of(logic id);
    return id ? OWN_M1 : OWN_M0;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Two-master request/grant bus plus the single RAM port.
// slave = arbiter side, master = masters and RAM side.
interface ram_port_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) ();

  logic              m0_req;
  logic              m0_we;
  logic              m0_lock;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic              m1_lock;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic              ram_ce;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output ram_ce, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  ram_ce, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/ram_port_arbiter_rr_lock_sel.sv
// Round-robin winner select with a bounded lock.
// Holds last_win, owner and lock_cnt.
module rr_lock_sel
  import ram_arb_pkg::*;
#(
  parameter int LOCK_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic lock0,
  input  logic lock1,
  output logic win_id,
  output logic win_vld
);

  localparam logic [8:0] LOCK_LIM = 9'(LOCK_MAX);

  logic       last_win_q, last_win_d;
  owner_t     owner_q, owner_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic [8:0] cnt_inc;
  logic       win_lock;
  logic       own_lock;

  // An idle owner still blocks the other master.
  always_comb begin
    win_vld = 1'b0;
    win_id  = MID_0;
    unique case (1'b1)
      owner_q == OWN_M0: begin
        win_vld = req0;
        win_id  = MID_0;
      end
      owner_q == OWN_M1: begin
        win_vld = req1;
        win_id  = MID_1;
      end
      owner_q == OWN_NONE && req0 && req1: begin
        win_vld = 1'b1;
        win_id  = ~last_win_q;
      end
      owner_q == OWN_NONE && req0 && !req1: begin
        win_vld = 1'b1;
        win_id  = MID_0;
      end
      owner_q == OWN_NONE && !req0 && req1: begin
        win_vld = 1'b1;
        win_id  = MID_1;
      end
      default: begin
        win_vld = 1'b0;
        win_id  = MID_0;
      end
    endcase
  end

  assign cnt_inc  = {1'b0, lock_cnt_q} + 9'd1;
  assign win_lock = win_id ? lock1 : lock0;
  assign own_lock = (owner_q == OWN_M1) ? lock1 : lock0;

  always_comb begin
    last_win_d = last_win_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    if (win_vld) begin
      last_win_d = win_id;
      if (win_lock && cnt_inc < LOCK_LIM) begin
        owner_d    = own_of(win_id);
        lock_cnt_d = cnt_inc[7:0];
      end else begin
        owner_d    = OWN_NONE;
        lock_cnt_d = 8'd0;
      end
    end else if (owner_q != OWN_NONE && !own_lock) begin
      owner_d    = OWN_NONE;
      lock_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_win_q <= MID_1;
      owner_q    <= OWN_NONE;
      lock_cnt_q <= 8'd0;
    end else begin
      last_win_q <= last_win_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for the single-port data RAM.
// Define RAM_ARB_STATS_EN to add grant/conflict counters.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W   = ARB_ADDR_W,
  parameter int DATA_W   = ARB_DATA_W,
  parameter int LOCK_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  ram_port_arbiter_if.slave bus
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [31:0] grant_cnt0,
  output logic [31:0] grant_cnt1,
  output logic [31:0] conflict_cnt
`endif
);

  logic              win_id;
  logic              win_vld;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  logic              rsp_pend_q, rsp_pend_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  rr_lock_sel #(
    .LOCK_MAX(LOCK_MAX)
  ) u_sel (
    .clk    (clk),
    .rst    (rst),
    .req0   (bus.m0_req),
    .req1   (bus.m1_req),
    .lock0  (bus.m0_lock),
    .lock1  (bus.m1_lock),
    .win_id (win_id),
    .win_vld(win_vld)
  );

  assign bus.m0_gnt = win_vld && win_id == MID_0;
  assign bus.m1_gnt = win_vld && win_id == MID_1;

  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    if (win_vld) begin
      win_we    = win_id ? bus.m1_we    : bus.m0_we;
      win_addr  = win_id ? bus.m1_addr  : bus.m0_addr;
      win_wdata = win_id ? bus.m1_wdata : bus.m0_wdata;
    end
  end

  assign bus.ram_ce    = win_vld;
  assign bus.ram_we    = win_we;
  assign bus.ram_addr  = win_addr;
  assign bus.ram_wdata = win_wdata;

  // rdata passes the RAM through on its response cycle, else holds.
  always_comb begin
    rsp_pend_d = win_vld && !win_we;
    rsp_id_d   = rsp_pend_d ? win_id : rsp_id_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    if (rsp_pend_q && rsp_id_q == MID_0) rdata0_d = bus.ram_rdata;
    if (rsp_pend_q && rsp_id_q == MID_1) rdata1_d = bus.ram_rdata;
  end

  assign bus.m0_rvalid = rsp_pend_q && rsp_id_q == MID_0;
  assign bus.m1_rvalid = rsp_pend_q && rsp_id_q == MID_1;
  assign bus.m0_rdata  = rdata0_d;
  assign bus.m1_rdata  = rdata1_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_pend_q <= 1'b0;
      rsp_id_q   <= MID_0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      rsp_pend_q <= rsp_pend_d;
      rsp_id_q   <= rsp_id_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

`ifdef RAM_ARB_STATS_EN
  logic [31:0] gcnt0_q, gcnt0_d;
  logic [31:0] gcnt1_q, gcnt1_d;
  logic [31:0] conf_q, conf_d;

  always_comb begin
    gcnt0_d = gcnt0_q + {31'd0, bus.m0_gnt};
    gcnt1_d = gcnt1_q + {31'd0, bus.m1_gnt};
    conf_d  = conf_q + {31'd0, bus.m0_req & bus.m1_req};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt0_q <= 32'd0;
      gcnt1_q <= 32'd0;
      conf_q  <= 32'd0;
    end else begin
      gcnt0_q <= gcnt0_d;
      gcnt1_q <= gcnt1_d;
      conf_q  <= conf_d;
    end
  end

  assign grant_cnt0   = gcnt0_q;
  assign grant_cnt1   = gcnt1_q;
  assign conflict_cnt = conf_q;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM.
// Counter checks are compiled in with RAM_ARB_STATS_EN.
module tb_ram_port_arbiter;

  logic clk;
  logic rst;
  int   errs;
  int   checks;

  ram_port_arbiter_if bus ();

`ifdef RAM_ARB_STATS_EN
  logic [31:0] gc0, gc1, cc;
`endif

  ram_port_arbiter dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef RAM_ARB_STATS_EN
    ,
    .grant_cnt0  (gc0),
    .grant_cnt1  (gc1),
    .conflict_cnt(cc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] mem [4096];
  logic [63:0] ram_q;

  always @(posedge clk) begin
    if (bus.ram_ce) begin
      if (bus.ram_we) mem[bus.ram_addr] = bus.ram_wdata;
      else ram_q <= mem[bus.ram_addr];
    end
  end
  assign bus.ram_rdata = ram_q;

  function automatic logic [63:0] pat(input logic [11:0] a);
    return 64'hC0DE_0000_0000_0000 | {52'd0, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic r, input logic we, input logic lk,
                      input logic [11:0] a, input logic [63:0] d);
    bus.m0_req = r; bus.m0_we = we; bus.m0_lock = lk;
    bus.m0_addr = a; bus.m0_wdata = d;
  endtask

  task automatic drv1(input logic r, input logic we, input logic lk,
                      input logic [11:0] a, input logic [63:0] d);
    bus.m1_req = r; bus.m1_we = we; bus.m1_lock = lk;
    bus.m1_addr = a; bus.m1_wdata = d;
  endtask

  initial begin
    errs = 0;
    checks = 0;
    ram_q = '0;
    for (int i = 0; i < 4096; i++) mem[i] = pat(12'(i));
    rst = 1'b1;
    drv0(0, 0, 0, 12'h0, 64'h0);
    drv1(0, 0, 0, 12'h0, 64'h0);

    // reset / idle
    @(negedge clk); #1;
    chk("rst_gnt0", bus.m0_gnt, 0);
    chk("rst_gnt1", bus.m1_gnt, 0);
    chk("rst_ce", bus.ram_ce, 0);
    chk("rst_rv0", bus.m0_rvalid, 0);
    chk("rst_rv1", bus.m1_rvalid, 0);
    chk("rst_rd0", bus.m0_rdata, 0);
    chk("rst_rd1", bus.m1_rdata, 0);
    rst = 1'b0;

    // single read by m0
    @(negedge clk);
    drv0(1, 0, 0, 12'h005, 64'h0);
    #1;
    chk("rd5_gnt0", bus.m0_gnt, 1);
    chk("rd5_gnt1", bus.m1_gnt, 0);
    chk("rd5_addr", bus.ram_addr, 12'h005);
    @(negedge clk);
    drv0(0, 0, 0, 12'h0, 64'h0);
    #1;
    chk("rd5_rv0", bus.m0_rvalid, 1);
    chk("rd5_rv1", bus.m1_rvalid, 0);
    chk("rd5_data", bus.m0_rdata, pat(12'h005));
    chk("idle_ce", bus.ram_ce, 0);

    // contended reads; m0 won last, so m1 goes first
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drv0(1, 0, 0, 12'h010, 64'h0);
      drv1(1, 0, 0, 12'h020, 64'h0);
      #1;
      chk("rr_gnt1", bus.m1_gnt, 64'(k % 2 == 0));
      chk("rr_gnt0", bus.m0_gnt, 64'(k % 2 == 1));
      if (k > 0) begin
        if ((k - 1) % 2 == 0) begin
          chk("rr_rv1", bus.m1_rvalid, 1);
          chk("rr_rd1", bus.m1_rdata, pat(12'h020));
        end else begin
          chk("rr_rv0", bus.m0_rvalid, 1);
          chk("rr_rd0", bus.m0_rdata, pat(12'h010));
        end
      end
    end
    @(negedge clk);
    drv0(0, 0, 0, 12'h0, 64'h0);
    drv1(0, 0, 0, 12'h0, 64'h0);
    #1;
    chk("rr_last_rv0", bus.m0_rvalid, 1);
    chk("rr_last_rd0", bus.m0_rdata, pat(12'h010));
    chk("rr_hold_rd1", bus.m1_rdata, pat(12'h020));

    // m1 write, m0 read back
    @(negedge clk);
    drv1(1, 1, 0, 12'h100, 64'hDEADBEEF_00000001);
    #1;
    chk("wr_gnt1", bus.m1_gnt, 1);
    chk("wr_we", bus.ram_we, 1);
    chk("wr_wdata", bus.ram_wdata, 64'hDEADBEEF_00000001);
    @(negedge clk);
    drv1(0, 0, 0, 12'h0, 64'h0);
    drv0(1, 0, 0, 12'h100, 64'h0);
    #1;
    chk("wr_no_rv1", bus.m1_rvalid, 0);
    chk("rb_gnt0", bus.m0_gnt, 1);
    @(negedge clk);
    drv0(0, 0, 0, 12'h0, 64'h0);
    #1;
    chk("rb_rv0", bus.m0_rvalid, 1);
    chk("rb_rd0", bus.m0_rdata, 64'hDEADBEEF_00000001);

    // locked burst by m1 against m0
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      drv0(1, 0, 0, 12'h300, 64'h0);
      drv1(1, 1, 1, 12'(12'h200 + k), 64'(64'h1000 + k));
      #1;
      chk("lk_gnt1", bus.m1_gnt, 64'(k < 8));
      chk("lk_gnt0", bus.m0_gnt, 64'(k == 8));
    end
    @(negedge clk);
    drv0(0, 0, 0, 12'h0, 64'h0);
    drv1(1, 0, 0, 12'h207, 64'h0);
    #1;
    chk("lk_rv0", bus.m0_rvalid, 1);
    chk("lk_rd0", bus.m0_rdata, pat(12'h300));
    chk("lk_rb_gnt1", bus.m1_gnt, 1);
    @(negedge clk);
    drv1(0, 0, 0, 12'h0, 64'h0);
    #1;
    chk("lk_rb_rv1", bus.m1_rvalid, 1);
    chk("lk_rb_rd1", bus.m1_rdata, 64'h1007);

    // idle owner keeps blocking until it drops lock
    @(negedge clk);
    drv1(1, 1, 1, 12'h210, 64'h55);
    #1;
    chk("blk_gnt1", bus.m1_gnt, 1);
    @(negedge clk);
    drv1(0, 0, 1, 12'h0, 64'h0);
    drv0(1, 0, 0, 12'h005, 64'h0);
    #1;
    chk("blk_gnt0_a", bus.m0_gnt, 0);
    chk("blk_ce", bus.ram_ce, 0);
    @(negedge clk);
    drv1(0, 0, 0, 12'h0, 64'h0);
    #1;
    chk("blk_gnt0_b", bus.m0_gnt, 0);
    @(negedge clk);
    #1;
    chk("blk_gnt0_c", bus.m0_gnt, 1);

    // reset lands on the granted read's response edge
    #2;
    rst = 1'b1;
    @(negedge clk);
    drv0(1, 0, 0, 12'h010, 64'h0);
    drv1(1, 0, 0, 12'h020, 64'h0);
    #1;
    chk("mr_rv0", bus.m0_rvalid, 0);
    chk("mr_rv1", bus.m1_rvalid, 0);
    chk("mr_rd0", bus.m0_rdata, 0);
    rst = 1'b0;

    // first post-reset tie goes to m0, then alternate
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      chk("pr_gnt0", bus.m0_gnt, 64'(k % 2 == 0));
      chk("pr_gnt1", bus.m1_gnt, 64'(k % 2 == 1));
    end
    @(negedge clk);
    drv0(0, 0, 0, 12'h0, 64'h0);
    drv1(0, 0, 0, 12'h0, 64'h0);
    #1;
    chk("pr_rv1", bus.m1_rvalid, 1);
    chk("pr_rd1", bus.m1_rdata, pat(12'h020));
`ifdef RAM_ARB_STATS_EN
    chk("st_conf", 64'(cc), 64'd10);
    chk("st_g0", 64'(gc0), 64'd5);
    chk("st_g1", 64'(gc1), 64'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
